// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiters: FSM encoding, op codes
// and the width of the optional per-core grant counters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int ARB_CNT_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending index scanning upward from
// last+1 (mod N). Reusable by any arbiter that keeps its own last pointer.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    // k runs 1..N so the previous winner is considered last
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!found && pending[IW'(c)]) begin
        found          = 1'b1;
        grant[IW'(c)]  = 1'b1;
        idx            = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NREQ cores.
// Define MEM_ARB_STATS_EN to add the per-core grant_cnt completion counters.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      rden,
  input  logic [NREQ-1:0]      wren,
  input  logic [NREQ*AW-1:0]   Address,
  input  logic [NREQ*DW-1:0]   Din,
  input  logic [DW-1:0]        RAMq,
  output logic [NREQ-1:0]      acq,
  output logic [NREQ*DW-1:0]   Dq,
  output logic [AW-1:0]        RAMAddress,
  output logic [DW-1:0]        RAMDin,
  output logic                 RAMwren
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NREQ*ARB_CNT_W-1:0] grant_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   win_id, last, pick_idx;
  logic [NREQ-1:0] pick_grant, win_oh, mask, pending;
  logic            pick_found, win_op;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_din;
  logic            sel_op;

  // The core just acknowledged still holds its request for one cycle
  assign pending = (rden | wren) & ~mask;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .pending (pending),
    .last    (last),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_op   = OP_RD;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr = Address[i*AW +: AW];
        sel_din  = Din[i*DW +: DW];
        sel_op   = wren[i] ? OP_WR : OP_RD;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NREQ; i++) win_oh[i] = (win_id == IW'(i));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = (win_op == OP_WR) ? ACK : CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset drops them immediately
  assign acq     = (state == ACK) ? win_oh : '0;
  assign RAMwren = (state == ISSUE) && (win_op == OP_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IW'(NREQ - 1);
      mask       <= '0;
      win_id     <= '0;
      win_op     <= OP_RD;
      RAMAddress <= '0;
      RAMDin     <= '0;
      Dq         <= '0;
    end else begin
      state <= state_nxt;
      mask  <= (state == ACK) ? win_oh : '0;
      // RAM address/data registers double as the latched operands
      if (state == IDLE && pick_found) begin
        win_id     <= pick_idx;
        win_op     <= sel_op;
        RAMAddress <= sel_addr;
        RAMDin     <= sel_din;
      end
      if (state == CAPTURE) begin
        for (int i = 0; i < NREQ; i++)
          if (win_oh[i]) Dq[i*DW +: DW] <= RAMq;
      end
      if (state == ACK) last <= win_id;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (state == ACK) begin
      for (int i = 0; i < NREQ; i++)
        if (win_oh[i])
          grant_cnt[i*ARB_CNT_W +: ARB_CNT_W] <=
            grant_cnt[i*ARB_CNT_W +: ARB_CNT_W] + ARB_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed scoreboard bench for mem_arbiter_rr (NREQ=3, AW=DW=8) with a
// behavioural single-port synchronous RAM.
module tb_mem_arbiter_rr;

  localparam int NREQ = 3;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     rden, wren;
  logic [NREQ*AW-1:0]  Address;
  logic [NREQ*DW-1:0]  Din;
  logic [DW-1:0]       RAMq;
  logic [NREQ-1:0]     acq;
  logic [NREQ*DW-1:0]  Dq;
  logic [AW-1:0]       RAMAddress;
  logic [DW-1:0]       RAMDin;
  logic                RAMwren;
`ifdef MEM_ARB_STATS_EN
  logic [NREQ*32-1:0]  grant_cnt;
`endif

  mem_arbiter_rr #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rden       (rden),
    .wren       (wren),
    .Address    (Address),
    .Din        (Din),
    .RAMq       (RAMq),
    .acq        (acq),
    .Dq         (Dq),
    .RAMAddress (RAMAddress),
    .RAMDin     (RAMDin),
    .RAMwren    (RAMwren)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first single-port RAM with a few preloaded words
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h11;
    mem[8'h31] = 8'h22;
    mem[8'h32] = 8'h33;
    RAMq = 8'h00;
    forever begin
      @(posedge clk);
      RAMq <= mem[RAMAddress];
      if (RAMwren) mem[RAMAddress] <= RAMDin;
    end
  end

  typedef struct {
    int          core;
    logic [23:0] dq;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [23:0] exp_dq;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_dq(input int core, input logic [7:0] v);
    exp_dq = (exp_dq & ~(24'hFF << (8 * core))) | (24'(v) << (8 * core));
  endtask

  task automatic drive(input int core, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [7:0] d);
    logic [2:0] b;
    b       = 3'(1) << core;
    rden    = rd ? (rden | b) : (rden & ~b);
    wren    = wr ? (wren | b) : (wren & ~b);
    Address = (Address & ~(24'hFF << (8 * core))) | (24'(a) << (8 * core));
    Din     = (Din & ~(24'hFF << (8 * core))) | (24'(d) << (8 * core));
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    exp_dq = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request from an idle arbiter; expected data is given by the caller
  task automatic do_req(input int core, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] d, input logic [7:0] rdata);
    int   t, wc;
    bit   got;
    exp_t e;
    @(posedge clk); #1;
    t = cyc;
    drive(core, rd, wr, a, d);
    if (rd && !wr) set_dq(core, rdata);
    e.core = core;
    e.dq   = exp_dq;
    e.cyc  = t + (wr ? 2 : 3);
    sb.push_back(e);
    wc  = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (RAMwren) wc++;
      if (((acq >> core) & 3'd1) != 3'd0) got = 1'b1;
    end
    check("acq_seen", 64'(got), 64'd1);
    check("wren_cycles", 64'(wc), wr ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    drive(core, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  always @(negedge clk) begin
    if (!rst && acq != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_acq", 64'(acq), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("acq_core", 64'(acq), 64'(3'(1) << mon_e.core));
        check("dq", 64'(Dq), 64'(mon_e.dq));
        check("acq_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] cdat [3];
  int         t0, n;
  exp_t       ce;

  initial begin
    cdat[0] = 8'h11; cdat[1] = 8'h22; cdat[2] = 8'h33;
    rden = '0; wren = '0; Address = '0; Din = '0;
    apply_reset();
    check("rst_acq", 64'(acq), 64'd0);
    check("rst_wren", 64'(RAMwren), 64'd0);
    check("rst_addr", 64'(RAMAddress), 64'd0);
    check("rst_din", 64'(RAMDin), 64'd0);
    check("rst_dq", 64'(Dq), 64'd0);

    do_req(1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
    check("dq1_a5", 64'(Dq[15:8]), 64'hA5);
    do_req(0, 1'b0, 1'b1, 8'h20, 8'h3C, 8'h00);
    do_req(2, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C);
    do_req(0, 1'b1, 1'b1, 8'h05, 8'h77, 8'h00);
    check("dq0_kept", 64'(Dq[7:0]), 64'h00);
    do_req(1, 1'b1, 1'b0, 8'h05, 8'h00, 8'h77);

    // Reset during CAPTURE of a core-1 read
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("cap_rst_acq", 64'(acq), 64'd0);
    check("cap_rst_wren", 64'(RAMwren), 64'd0);
    check("cap_rst_addr", 64'(RAMAddress), 64'd0);
    check("cap_rst_din", 64'(RAMDin), 64'd0);
    check("cap_rst_dq", 64'(Dq), 64'd0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    exp_dq = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    do_req(1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);

    // Reset during ISSUE of a write must drop RAMwren at once
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 8'h40, 8'h99);
    repeat (2) @(negedge clk);
    check("iss_wren_hi", 64'(RAMwren), 64'd1);
    rst = 1'b1;
    #1;
    check("iss_rst_wren", 64'(RAMwren), 64'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp_dq = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // All cores request continuously from reset
    rst    = 1'b1;
    exp_dq = '0;
    for (int c = 0; c < 3; c++) drive(c, 1'b1, 1'b0, 8'h30 + 8'(c), 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      set_dq(k % 3, cdat[k % 3]);
      ce.core = k % 3;
      ce.dq   = exp_dq;
      ce.cyc  = t0 + 3 + 4 * k;
      sb.push_back(ce);
    end
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      if (acq != '0) n++;
    end
    check("rr_grants", 64'(n), 64'd6);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) drive(c, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (6) @(posedge clk);

`ifdef MEM_ARB_STATS_EN
    apply_reset();
    for (int k = 0; k < 5; k++) do_req(2, 1'b0, 1'b1, 8'h50 + 8'(k), 8'(k), 8'h00);
    for (int k = 0; k < 2; k++) do_req(0, 1'b0, 1'b1, 8'h60 + 8'(k), 8'(k), 8'h00);
    @(negedge clk);
    check("cnt2", 64'(grant_cnt[95:64]), 64'd5);
    check("cnt1", 64'(grant_cnt[63:32]), 64'd0);
    check("cnt0", 64'(grant_cnt[31:0]), 64'd2);
`endif

    repeat (4) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
